// File: rtl/fifo_arb_ctrl.sv
// N-way write arbiter feeding a sync_fifo, plus a registered read side that presents FIFO words on a valid/ready stream.
// Define FIFO_ARB_FIXED_PRIO_EN for lowest-index-wins arbitration; otherwise requesters are served round-robin.
module fifo_arb_ctrl #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [NREQ-1:0]       i_req_valid,
    input  logic [NREQ*WIDTH-1:0] i_req_data,
    output logic [NREQ-1:0]       o_req_ready,
    output logic                  o_fifo_wr_en,
    output logic [WIDTH-1:0]      o_fifo_wr_data,
    output logic                  o_fifo_rd_en,
    input  logic [WIDTH-1:0]      i_fifo_rd_data,
    input  logic                  i_fifo_full,
    input  logic                  i_fifo_empty,
    output logic                  o_m_valid,
    output logic [WIDTH-1:0]      o_m_data,
    input  logic                  i_m_ready
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } rd_state_t;

    rd_state_t        state;
    rd_state_t        state_nxt;
    logic [PTR_W-1:0] grant_idx;
    logic [PTR_W-1:0] cand;
    logic             grant_hit;
    logic             wr_ok;
    logic             rd_req;
    logic             m_valid_nxt;
    logic [WIDTH-1:0] m_data_nxt;

`ifdef FIFO_ARB_FIXED_PRIO_EN
    // Scan from the top down so the last hit, the lowest index, wins.
    always_comb begin
        grant_idx = '0;
        grant_hit = 1'b0;
        cand      = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            cand = PTR_W'(i);
            if (i_req_valid[cand]) begin
                grant_hit = 1'b1;
                grant_idx = cand;
            end
        end
    end
`else
    logic [PTR_W-1:0] rr_ptr;

    always_comb begin
        grant_idx = '0;
        grant_hit = 1'b0;
        cand      = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = PTR_W'((int'(rr_ptr) + i) % NREQ);
            if (!grant_hit && i_req_valid[cand]) begin
                grant_hit = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rr_ptr <= '0;
        end else if (wr_ok) begin
            rr_ptr <= (grant_idx == PTR_W'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end
`endif

    // Write side is purely combinational: the granted word goes to the FIFO in the same cycle.
    assign wr_ok = i_rst_n & grant_hit & ~i_fifo_full;

    always_comb begin
        o_req_ready = '0;
        if (wr_ok) begin
            o_req_ready[grant_idx] = 1'b1;
        end
    end

    assign o_fifo_wr_en   = wr_ok;
    assign o_fifo_wr_data = i_req_data[int'(grant_idx) * WIDTH +: WIDTH];

    always_comb begin
        state_nxt   = state;
        rd_req      = 1'b0;
        m_valid_nxt = o_m_valid;
        m_data_nxt  = o_m_data;
        case (state)
            IDLE: begin
                if (!i_fifo_empty) begin
                    rd_req    = 1'b1;
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                m_valid_nxt = 1'b1;
                m_data_nxt  = i_fifo_rd_data;
                state_nxt   = HOLD;
            end
            HOLD: begin
                if (i_m_ready) begin
                    m_valid_nxt = 1'b0;
                    if (!i_fifo_empty) begin
                        rd_req    = 1'b1;
                        state_nxt = FETCH;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // The FIFO pops unguarded, so the strobe is also held off while reset is asserted.
    assign o_fifo_rd_en = rd_req & i_rst_n;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            o_m_valid <= 1'b0;
            o_m_data  <= '0;
        end else begin
            state     <= state_nxt;
            o_m_valid <= m_valid_nxt;
            o_m_data  <= m_data_nxt;
        end
    end

endmodule

// File: doc/fifo_arb_ctrl.md
FIFO_ARB_CTRL -- requirements
Module: fifo_arb_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: data word width in bits, shared with the attached sync_fifo.
REQ-002 The block SHALL have parameter NREQ, default 2, range 2..8: number of write requesters.
REQ-003 The block SHALL have port i_clk, input, 1: the single clock; all state is on its rising edge.
REQ-004 The block SHALL have port i_rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 The block SHALL have port i_req_valid, input, NREQ: requester k has a word to write.
REQ-006 The block SHALL have port i_req_data, input, NREQ*WIDTH: requester k data in bits [k*WIDTH +: WIDTH].
REQ-007 The block SHALL have port o_req_ready, output, NREQ: one-hot grant; requester k's word is accepted this cycle when valid[k] and ready[k] are both high.
REQ-008 The block SHALL have port o_fifo_wr_en, output, 1: FIFO write strobe.
REQ-009 The block SHALL have port o_fifo_wr_data, output, WIDTH: FIFO write data.
REQ-010 The block SHALL have port o_fifo_rd_en, output, 1: FIFO read strobe.
REQ-011 The block SHALL have port i_fifo_rd_data, input, WIDTH: FIFO read data, valid the cycle after o_fifo_rd_en.
REQ-012 The block SHALL have ports i_fifo_full and i_fifo_empty, input, 1 each: FIFO status flags.
REQ-013 The block SHALL have port o_m_valid, output, 1: output stream valid.
REQ-014 The block SHALL have port o_m_data, output, WIDTH: output stream data.
REQ-015 The block SHALL have port i_m_ready, input, 1: the downstream consumer accepts the word when valid and ready are both high.

Function
REQ-016 o_fifo_wr_en SHALL never be high while i_fifo_full is high, and o_fifo_rd_en SHALL never be high while i_fifo_empty is high, because the FIFO advances its pointers unguarded.
REQ-017 Write arbitration SHALL be combinational: at most one o_req_ready bit is high; none are high while i_fifo_full is high.
REQ-018 Round-robin arbitration SHALL grant the first valid requester at or after the pointer rr_ptr, wrapping from NREQ-1 to 0.
REQ-019 After each accepted write from requester k, rr_ptr SHALL become (k+1) mod NREQ; when no write is accepted, rr_ptr SHALL hold.
REQ-020 o_fifo_wr_en SHALL equal OR(i_req_valid & o_req_ready), and o_fifo_wr_data SHALL equal the granted requester's data, so every accepted word reaches the FIFO in the same cycle (zero latency).
REQ-021 The read FSM SHALL have states IDLE, FETCH and HOLD.
REQ-022 In IDLE, when !i_fifo_empty, the FSM SHALL assert o_fifo_rd_en and go to FETCH; otherwise it SHALL stay in IDLE.
REQ-023 In FETCH, the FSM SHALL register i_fifo_rd_data into o_m_data, set o_m_valid, and go to HOLD.
REQ-024 In HOLD, o_m_valid and o_m_data SHALL be held stable until i_m_ready is high.
REQ-025 In HOLD with i_m_ready high: if !i_fifo_empty, the FSM SHALL assert o_fifo_rd_en, clear o_m_valid and go to FETCH; otherwise it SHALL clear o_m_valid and go to IDLE.
REQ-026 Read throughput SHALL be at most 1 word per 2 cycles.
REQ-027 Latency from !i_fifo_empty in IDLE to o_m_valid SHALL be 2 cycles.
REQ-028 A write and a read in the same cycle SHALL both proceed independently.
REQ-029 Words SHALL leave o_m_data in exactly the order the FIFO stores them, with no loss and no duplication.

Reset
REQ-030 While i_rst_n is low, regardless of i_clk: o_m_valid=0, o_m_data=0, FSM=IDLE, rr_ptr=0, o_fifo_rd_en=0.
REQ-031 While i_rst_n is low, o_req_ready and o_fifo_wr_en SHALL be forced to 0.
REQ-032 Reset asserted mid-transfer SHALL discard the word held in HOLD. Resetting the FIFO is the integrator's responsibility.
REQ-033 The first arbitration or FIFO read SHALL occur on the first rising edge after i_rst_n is released.

Configuration
REQ-034 Macro FIFO_ARB_FIXED_PRIO_EN SHALL select the arbitration scheme.
REQ-035 When FIFO_ARB_FIXED_PRIO_EN is defined, the lowest-index valid requester SHALL always win and rr_ptr logic SHALL be omitted.
REQ-036 When FIFO_ARB_FIXED_PRIO_EN is undefined, round-robin arbitration per REQ-018 and REQ-019 SHALL apply.
REQ-037 Read-side behaviour SHALL be identical in both configurations.

Verification
REQ-038 Scenario, NREQ=2: both requesters hold valid continuously with data 0xA0.. and 0xB0.. incrementing, FIFO not full -> writes alternate A0,B0,A1,B1 (fixed priority: A0,A1,A2...).
REQ-039 Scenario: FIFO full and both requesters valid -> o_req_ready=00 and o_fifo_wr_en=0; after one pop, exactly one write is accepted.
REQ-040 Scenario: write 0x11,0x22,0x33 with i_m_ready=1 -> o_m_data presents 0x11,0x22,0x33 in order, each valid for 1 cycle, 2 cycles apart.
REQ-041 Scenario: i_m_ready=0 for 10 cycles with word 0x5A held -> o_m_valid=1 and o_m_data=0x5A stable, with no o_fifo_rd_en during the stall.
REQ-042 Scenario: assert i_rst_n low in HOLD between clock edges -> o_m_valid=0 immediately, and after release the FSM returns to IDLE with rr_ptr=0.
REQ-043 Scenario: fill the FIFO to empty boundary, then write and read simultaneously -> no rd_en while empty and no wr_en while full; the scoreboard matches all words.
